// File: rtl/bus_rr_arbiter_if.sv
// Shared-bus arbitration interface: per-master requests, slave handshake,
// and the arbiter's grant/ownership outputs.
interface bus_rr_arbiter_if #(
  parameter int N = 8
);
  localparam int OW = $clog2(N);

  logic [N-1:0]  dma;
  logic          ready;
  logic          lock;
  logic [N-1:0]  grant;
  logic          req;
  logic [OW-1:0] owner;
  logic          timeout;

  // The arbiter side drives ownership; requesters and the slave drive the rest.
  modport master (
    input  dma, ready, lock,
    output grant, req, owner, timeout
  );

  modport slave (
    output dma, ready, lock,
    input  grant, req, owner, timeout
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant, bus lock and a
// turnaround cycle. Define BUS_TIMEOUT_EN to add the transfer watchdog.
module bus_rr_arbiter #(
  parameter int N       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  bus_rr_arbiter_if.master bus
);
  localparam int OW = $clog2(N);

  if (N < 2 || N > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("bus_rr_arbiter: N must be 2..16 and TIMEOUT 1..255");
  end

  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q, last_d;
  logic [OW-1:0] scan_idx;
  logic [OW-1:0] pick;
  logic          found;
`ifdef BUS_TIMEOUT_EN
  logic [7:0]    cnt_q, cnt_d;
  logic          tout_q, tout_d;
`endif

  // Search starts one past the last served master so nobody starves.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int i = 1; i <= N; i++) begin
      scan_idx = OW'((int'(last_q) + i) % N);
      if (!found && bus.dma[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= OW'(N - 1);
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = BUSY;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          owner_d       = pick;
`ifdef BUS_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end
      BUSY: begin
        // Event priority: locked follow-on, completion, abandonment, watchdog.
        if (bus.ready && bus.lock && bus.dma[owner_q]) begin
`ifdef BUS_TIMEOUT_EN
          cnt_d = '0;
`endif
        end else if (bus.ready || !bus.dma[owner_q]) begin
          state_d = TURN;
          grant_d = '0;
          last_d  = owner_q;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT)) begin
          state_d = TURN;
          grant_d = '0;
          last_d  = owner_q;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant   = grant_q;
    bus.req     = |grant_q;
    bus.owner   = owner_q;
`ifdef BUS_TIMEOUT_EN
    bus.timeout = tout_q;
`else
    bus.timeout = 1'b0;
`endif
  end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: per-cycle vector tables fed
// through an expectation queue, plus hand-written reset and watchdog cases.
module tb_bus_rr_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_rr_arbiter_if #(.N(8)) bus ();

  bus_rr_arbiter #(.N(8), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [7:0] dma;
    logic       ready;
    logic       lock;
    logic [7:0] grant;
    logic [2:0] owner;
    logic       tout;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [7:0] d, input logic r, input logic l,
                              input logic [7:0] g, input logic [2:0] o, input logic t);
    tbl.push_back('{dma: d, ready: r, lock: l, grant: g, owner: o, tout: t});
  endfunction

  // One table row per clock: drive at negedge, compare just after posedge.
  task automatic run_tbl(input string name);
    vec_t e;
    foreach (tbl[i]) begin
      @(negedge clk);
      bus.dma   = tbl[i].dma;
      bus.ready = tbl[i].ready;
      bus.lock  = tbl[i].lock;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d].grant", name, i), bus.grant, e.grant);
      check($sformatf("%s[%0d].req", name, i), bus.req, |e.grant);
      check($sformatf("%s[%0d].timeout", name, i), bus.timeout, e.tout);
      if (e.grant != 8'h00)
        check($sformatf("%s[%0d].owner", name, i), bus.owner, e.owner);
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    bus.dma   = '0;
    bus.ready = 1'b0;
    bus.lock  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    bus.dma   = '0;
    bus.ready = 1'b0;
    bus.lock  = 1'b0;
    #12;
    check("reset.grant", bus.grant, 8'h00);
    check("reset.req", bus.req, 1'b0);
    check("reset.owner", bus.owner, 3'd0);
    check("reset.timeout", bus.timeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with ready/lock asserted does nothing; then 0x81 alternates 0 and 7.
    add(8'h00, 1, 1, 8'h00, 0, 0);
    add(8'h81, 0, 0, 8'h01, 0, 0);
    add(8'h81, 1, 0, 8'h00, 0, 0);
    add(8'h81, 0, 0, 8'h00, 0, 0);
    add(8'h81, 0, 0, 8'h80, 7, 0);
    add(8'h81, 1, 0, 8'h00, 0, 0);
    add(8'h81, 0, 0, 8'h00, 0, 0);
    add(8'h81, 0, 0, 8'h01, 0, 0);
    run_tbl("alt");

    // Full sweep: every master in turn, two dead cycles between tenures.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      add(8'hFF, 0, 0, 8'(1 << i), 3'(i), 0);
      add(8'hFF, 1, 0, 8'h00, 0, 0);
      add(8'hFF, 0, 0, 8'h00, 0, 0);
    end
    add(8'hFF, 0, 0, 8'h01, 0, 0);
    run_tbl("sweep");

    // Owner 3 keeps the bus across three locked ready pulses.
    do_reset();
    add(8'h08, 0, 0, 8'h08, 3, 0);
    add(8'h0F, 1, 1, 8'h08, 3, 0);
    add(8'h0F, 0, 1, 8'h08, 3, 0);
    add(8'h0F, 1, 1, 8'h08, 3, 0);
    add(8'h0F, 1, 1, 8'h08, 3, 0);
    add(8'h0F, 1, 0, 8'h00, 0, 0);
    add(8'h0F, 0, 0, 8'h00, 0, 0);
    add(8'h0F, 0, 0, 8'h01, 0, 0);
    run_tbl("lock");

    // Owner 2 abandons; then lock is ignored once the owner's request drops.
    do_reset();
    add(8'h04, 0, 0, 8'h04, 2, 0);
    add(8'h04, 0, 0, 8'h04, 2, 0);
    add(8'h19, 0, 0, 8'h00, 0, 0);
    add(8'h19, 0, 0, 8'h00, 0, 0);
    add(8'h19, 0, 0, 8'h08, 3, 0);
    add(8'h17, 1, 1, 8'h00, 0, 0);
    add(8'h17, 0, 0, 8'h00, 0, 0);
    add(8'h17, 0, 0, 8'h10, 4, 0);
    run_tbl("abandon");

    // Asynchronous reset mid-tenure clears the bus before the next edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.grant", bus.grant, 8'h00);
    check("midrst.req", bus.req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    add(8'h81, 0, 0, 8'h01, 0, 0);
    run_tbl("restart");

`ifdef BUS_TIMEOUT_EN
    // TIMEOUT=4: pulse in the 6th cycle after grant; ready on expiry wins.
    do_reset();
    add(8'h03, 0, 0, 8'h01, 0, 0);
    for (int i = 0; i < 4; i++) add(8'h03, 0, 0, 8'h01, 0, 0);
    add(8'h03, 0, 0, 8'h00, 0, 1);
    add(8'h03, 0, 0, 8'h00, 0, 0);
    add(8'h03, 0, 0, 8'h02, 1, 0);
    for (int i = 0; i < 4; i++) add(8'h03, 0, 0, 8'h02, 1, 0);
    add(8'h03, 1, 0, 8'h00, 0, 0);
    add(8'h03, 0, 0, 8'h00, 0, 0);
    add(8'h03, 0, 0, 8'h01, 0, 0);
    run_tbl("watchdog");
`else
    // Without the watchdog a tenure waits indefinitely for ready.
    do_reset();
    add(8'h01, 0, 0, 8'h01, 0, 0);
    for (int i = 0; i < 20; i++) add(8'h01, 0, 0, 8'h01, 0, 0);
    add(8'h01, 1, 0, 8'h00, 0, 0);
    run_tbl("nowatchdog");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: got running expected finished");
    $fatal(1, "time limit");
  end
endmodule
